// File: rtl/ahb_lite_regslave.sv
// AHB-Lite register-file subordinate with programmable wait states, two-cycle ERROR response and doorbell irq.
// Latency: WAIT_CYC+1 cycles per OKAY transfer, 2 cycles per ERROR; stalls the bus via hreadyout in WAIT/ERR1.
module ahb_lite_regslave #(
   parameter int          NREG     = 16,
   parameter int          WAIT_CYC = 0,
   parameter logic [31:0] ID_VAL   = 32'hC0FF_EE01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [31:0] hwdata,
   input  logic        hready,
   output logic [31:0] hrdata,
   output logic        hreadyout,
   output logic        hresp,
   output logic        irq
);

   localparam int         AW  = $clog2(NREG);
   localparam logic [12:0] LIM = 13'(NREG * 4);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

   state_t        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [1:0]    lane_q, lane_d;
   logic [1:0]    size_q, size_d;
   logic          write_q, write_d;
   logic          irq_q, irq_d;
   logic [31:0]   regs_q [NREG];

   logic          cap;
   logic          illegal;
   logic          commit;
   logic [3:0]    be;
   logic [31:0]   wmask;
   logic          unused_bits;

   assign unused_bits = ^{haddr[31:12], htrans[0]};

   // Only states that present hreadyout=1 may accept a new address phase.
   always_comb begin
      cap = hsel & htrans[1] & hready &
            ((state_q == S_IDLE) | (state_q == S_LAST) | (state_q == S_ERR2));
      illegal = ({1'b0, haddr[11:0]} >= LIM) |
                (hsize > 3'd2) |
                ((hsize == 3'd1) & haddr[0]) |
                ((hsize == 3'd2) & (haddr[1:0] != 2'b00));
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      lane_d  = lane_q;
      size_d  = size_q;
      write_d = write_q;
      case (state_q)
         S_WAIT: begin
            if (cnt_q == 3'd1) begin
               state_d = S_LAST;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         S_ERR1: state_d = S_ERR2;
         default: begin
            state_d = S_IDLE;
            if (cap) begin
               idx_d   = haddr[AW+1:2];
               lane_d  = haddr[1:0];
               size_d  = hsize[1:0];
               write_d = hwrite;
               if (illegal) begin
                  state_d = S_ERR1;
               end else if (WAIT_CYC > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = 3'(WAIT_CYC);
               end else begin
                  state_d = S_LAST;
               end
            end
         end
      endcase
   end

   always_comb begin
      commit = (state_q == S_LAST) & write_q;
      case (size_q)
         2'd0:    be = 4'b0001 << lane_q;
         2'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   end

   // A doorbell write sets the pending bit; reg1 clears it only when lane 0 carries a 1.
   always_comb begin
      irq_d = irq_q;
      if (commit && idx_q == AW'(2)) begin
         irq_d = 1'b1;
      end else if (commit && idx_q == AW'(1) && be[0] && hwdata[0]) begin
         irq_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         lane_q  <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         lane_q  <= lane_d;
         size_q  <= size_d;
         write_q <= write_d;
         irq_q   <= irq_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (commit && idx_q > AW'(1)) begin
         regs_q[idx_q] <= (regs_q[idx_q] & ~wmask) | (hwdata & wmask);
      end
   end

   // Read data comes straight from the register array so a write committed on the
   // previous edge is visible to a pipelined read of the same word.
   always_comb begin
      hrdata = '0;
      if (state_q == S_LAST && !write_q) begin
         if (idx_q == AW'(0)) begin
            hrdata = ID_VAL;
         end else if (idx_q == AW'(1)) begin
            hrdata = {31'b0, irq_q};
         end else begin
            hrdata = regs_q[idx_q];
         end
      end
   end

   assign hreadyout = (state_q != S_WAIT) && (state_q != S_ERR1);
   assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
   assign irq       = irq_q;

endmodule

// File: tb/tb_ahb_lite_regslave.sv
// Directed bench: one instance with zero wait states, one with three; sel chooses which one is driven and observed.
module tb_ahb_lite_regslave;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        hsel, hwrite;
   logic [31:0] haddr, hwdata;
   logic [1:0]  htrans;
   logic [2:0]  hsize;

   logic [31:0] rd0, rd3;
   logic        ro0, ro3, rs0, rs3, irq0, irq3;
   logic        hsel0, hsel3;
   logic [31:0] hrdata_m;
   logic        hreadyout_m, hresp_m, irq_m;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign hsel0       = hsel & ~sel;
   assign hsel3       = hsel & sel;
   assign hrdata_m    = sel ? rd3 : rd0;
   assign hreadyout_m = sel ? ro3 : ro0;
   assign hresp_m     = sel ? rs3 : rs0;
   assign irq_m       = sel ? irq3 : irq0;

   ahb_lite_regslave #(.NREG(16), .WAIT_CYC(0), .ID_VAL(32'hC0FF_EE01)) u_dut0 (
      .clk(clk), .rst(rst), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(ro0),
      .hrdata(rd0), .hreadyout(ro0), .hresp(rs0), .irq(irq0));

   ahb_lite_regslave #(.NREG(16), .WAIT_CYC(3), .ID_VAL(32'hC0FF_EE01)) u_dut3 (
      .clk(clk), .rst(rst), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(ro3),
      .hrdata(rd3), .hreadyout(ro3), .hresp(rs3), .irq(irq3));

   typedef struct {
      logic        wr;
      logic [2:0]  size;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic addr_phase(input logic wr, input logic [2:0] size, input logic [11:0] addr);
      hsel   = 1'b1;
      htrans = 2'b10;
      hwrite = wr;
      hsize  = size;
      haddr  = {20'h0, addr};
   endtask

   task automatic idle_bus();
      hsel   = 1'b0;
      htrans = 2'b00;
   endtask

   // Counts the data-phase negedges with hreadyout low, bounded so a stuck slave cannot hang the run.
   task automatic wait_ready(output int waits);
      waits = 0;
      while (!hreadyout_m && waits < 20) begin
         waits++;
         @(negedge clk);
      end
   endtask

   task automatic xfer(input logic wr, input logic [2:0] size, input logic [11:0] addr,
                       input logic [31:0] wdata, output logic resp, output logic [31:0] rdata,
                       output int waits);
      @(negedge clk);
      addr_phase(wr, size, addr);
      @(posedge clk);
      @(negedge clk);
      idle_bus();
      hwdata = wdata;
      wait_ready(waits);
      resp  = hresp_m;
      rdata = hrdata_m;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic        resp;
      logic [31:0] rdata;
      int          waits;

      vecs[0]  = '{1'b0, 3'd2, 12'h000, 32'h0,         1'b0, 32'hC0FF_EE01};
      vecs[1]  = '{1'b1, 3'd2, 12'h000, 32'h1234_5678, 1'b0, 32'h0};
      vecs[2]  = '{1'b0, 3'd2, 12'h000, 32'h0,         1'b0, 32'hC0FF_EE01};
      vecs[3]  = '{1'b1, 3'd2, 12'h010, 32'hDEAD_BEEF, 1'b0, 32'h0};
      vecs[4]  = '{1'b1, 3'd0, 12'h012, 32'h00AA_0000, 1'b0, 32'h0};
      vecs[5]  = '{1'b0, 3'd2, 12'h010, 32'h0,         1'b0, 32'hDEAA_BEEF};
      vecs[6]  = '{1'b1, 3'd1, 12'h010, 32'h0000_5555, 1'b0, 32'h0};
      vecs[7]  = '{1'b0, 3'd2, 12'h010, 32'h0,         1'b0, 32'hDEAA_5555};
      vecs[8]  = '{1'b0, 3'd2, 12'h040, 32'h0,         1'b1, 32'h0};
      vecs[9]  = '{1'b1, 3'd2, 12'h006, 32'hFFFF_FFFF, 1'b1, 32'h0};
      vecs[10] = '{1'b1, 3'd3, 12'h010, 32'hFFFF_FFFF, 1'b1, 32'h0};
      vecs[11] = '{1'b1, 3'd1, 12'h011, 32'hFFFF_FFFF, 1'b1, 32'h0};
      vecs[12] = '{1'b0, 3'd2, 12'h010, 32'h0,         1'b0, 32'hDEAA_5555};
      vecs[13] = '{1'b1, 3'd2, 12'h03C, 32'hA5A5_0F0F, 1'b0, 32'h0};
      vecs[14] = '{1'b0, 3'd2, 12'h03C, 32'h0,         1'b0, 32'hA5A5_0F0F};
      vecs[15] = '{1'b0, 3'd2, 12'h004, 32'h0,         1'b0, 32'h0};

      rst = 1'b1; sel = 1'b0; hsel = 1'b0; hwrite = 1'b0;
      haddr = '0; hwdata = '0; htrans = 2'b00; hsize = 3'd2;

      repeat (2) @(negedge clk);
      chk("reset_hreadyout", {31'b0, hreadyout_m}, 32'd1);
      chk("reset_hresp", {31'b0, hresp_m}, 32'd0);
      chk("reset_hrdata", hrdata_m, 32'h0);
      chk("reset_irq", {31'b0, irq_m}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         xfer(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, resp, rdata, waits);
         chk($sformatf("vec%0d_resp", i), {31'b0, resp}, {31'b0, vecs[i].exp_err});
         chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_waits", i), waits, vecs[i].exp_err ? 32'd1 : 32'd0);
      end

      // Pipelined write then read of the same word with no bubble.
      @(negedge clk);
      addr_phase(1'b1, 3'd2, 12'h014);
      @(posedge clk);
      @(negedge clk);
      hwdata = 32'hCAFE_F00D;
      chk("pipe0_write_last_ready", {31'b0, hreadyout_m}, 32'd1);
      addr_phase(1'b0, 3'd2, 12'h014);
      @(posedge clk);
      @(negedge clk);
      idle_bus();
      chk("pipe0_read_ready", {31'b0, hreadyout_m}, 32'd1);
      chk("pipe0_read_resp", {31'b0, hresp_m}, 32'd0);
      chk("pipe0_read_data", hrdata_m, 32'hCAFE_F00D);

      // ERROR with a manager IDLE in ERR1, then a legal read captured in ERR2.
      @(negedge clk);
      addr_phase(1'b0, 3'd2, 12'h040);
      @(posedge clk);
      @(negedge clk);
      idle_bus();
      chk("err1_ready", {31'b0, hreadyout_m}, 32'd0);
      chk("err1_resp", {31'b0, hresp_m}, 32'd1);
      chk("err1_rdata", hrdata_m, 32'h0);
      @(posedge clk);
      @(negedge clk);
      chk("err2_ready", {31'b0, hreadyout_m}, 32'd1);
      chk("err2_resp", {31'b0, hresp_m}, 32'd1);
      addr_phase(1'b0, 3'd2, 12'h010);
      @(posedge clk);
      @(negedge clk);
      idle_bus();
      chk("after_err_ready", {31'b0, hreadyout_m}, 32'd1);
      chk("after_err_resp", {31'b0, hresp_m}, 32'd0);
      chk("after_err_data", hrdata_m, 32'hDEAA_5555);

      // Doorbell: irq rises two cycles after the address phase.
      @(negedge clk);
      addr_phase(1'b1, 3'd2, 12'h008);
      @(posedge clk);
      @(negedge clk);
      idle_bus();
      hwdata = 32'h1;
      chk("db_irq_in_last", {31'b0, irq_m}, 32'd0);
      @(negedge clk);
      chk("db_irq_set", {31'b0, irq_m}, 32'd1);
      xfer(1'b0, 3'd2, 12'h004, 32'h0, resp, rdata, waits);
      chk("irqstat_read", rdata, 32'h1);
      xfer(1'b0, 3'd2, 12'h008, 32'h0, resp, rdata, waits);
      chk("doorbell_read", rdata, 32'h1);
      xfer(1'b1, 3'd2, 12'h004, 32'h0, resp, rdata, waits);
      @(negedge clk);
      chk("irq_w0_keeps", {31'b0, irq_m}, 32'd1);
      xfer(1'b1, 3'd2, 12'h004, 32'h1, resp, rdata, waits);
      @(negedge clk);
      chk("irq_w1_clears", {31'b0, irq_m}, 32'd0);

      // Three wait states.
      sel = 1'b1;
      xfer(1'b0, 3'd2, 12'h014, 32'h0, resp, rdata, waits);
      chk("w3_read_waits", waits, 32'd3);
      chk("w3_read_resp", {31'b0, resp}, 32'd0);
      chk("w3_read_data", rdata, 32'h0);

      @(negedge clk);
      addr_phase(1'b1, 3'd2, 12'h014);
      @(posedge clk);
      @(negedge clk);
      idle_bus();
      hwdata = 32'h0BAD_CAFE;
      wait_ready(waits);
      chk("w3_pipe_write_waits", waits, 32'd3);
      addr_phase(1'b0, 3'd2, 12'h014);
      @(posedge clk);
      @(negedge clk);
      idle_bus();
      chk("w3_pipe_no_bubble", {31'b0, hreadyout_m}, 32'd0);
      @(negedge clk);
      wait_ready(waits);
      chk("w3_pipe_read_waits", waits + 1, 32'd3);
      chk("w3_pipe_read_data", hrdata_m, 32'h0BAD_CAFE);

      // Asynchronous reset during the WAIT of a write.
      xfer(1'b1, 3'd2, 12'h008, 32'h1, resp, rdata, waits);
      @(negedge clk);
      chk("w3_irq_set", {31'b0, irq_m}, 32'd1);
      @(negedge clk);
      addr_phase(1'b1, 3'd2, 12'h018);
      @(posedge clk);
      @(negedge clk);
      idle_bus();
      hwdata = 32'h1111_2222;
      chk("rst_pre_ready", {31'b0, hreadyout_m}, 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_ready", {31'b0, hreadyout_m}, 32'd1);
      chk("rst_async_resp", {31'b0, hresp_m}, 32'd0);
      chk("rst_async_irq", {31'b0, irq_m}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      xfer(1'b0, 3'd2, 12'h018, 32'h0, resp, rdata, waits);
      chk("rst_read_data", rdata, 32'h0);
      chk("rst_read_waits", waits, 32'd3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
